// File: rtl/result_display_pkg.sv
// Shared types and constants for the result display: FSM state encoding,
// 7-segment codes (a..g on bits 7..1, dp on bit 0) and digit enables.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [2:0] DIG_OFF   = 3'b000;
  localparam logic [2:0] DIG_ONES  = 3'b001;
  localparam logic [2:0] DIG_TENS  = 3'b010;
  localparam logic [2:0] DIG_HUNDS = 3'b100;

  // Decimal digit to segment pattern; non-decimal values show blank.
  function automatic logic [7:0] seg_code(input logic [3:0] val);
    logic [7:0] code;
    case (val)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Scan position (0 = ones) to one-hot digit enable.
  function automatic logic [2:0] digit_onehot(input logic [1:0] pos);
    logic [2:0] dig;
    case (pos)
      2'd0:    dig = DIG_ONES;
      2'd1:    dig = DIG_TENS;
      2'd2:    dig = DIG_HUNDS;
      default: dig = DIG_OFF;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// Capture/display bundle between the result source and the display block.
interface result_display_if;
  logic       load;
  logic [7:0] r00;
  logic [7:0] r01;
  logic [7:0] r10;
  logic [7:0] r11;
  logic [2:0] digit;
  logic [7:0] seg_data;
  logic       busy;

  modport master (output load, r00, r01, r10, r11, input digit, seg_data, busy);
  modport slave  (input load, r00, r01, r10, r11, output digit, seg_data, busy);
endinterface

// File: rtl/result_display_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one iteration per
// cycle. A start pulse always (re)loads the operand, aborting any conversion.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [7:0]  shift_r;
  logic [11:0] bcd_r;
  logic [2:0]  iter_r;
  logic        run_r;
  logic        done_r;
  logic [11:0] adj_s;

  // Add-3 correction on every BCD nibble that is 5 or more before the shift.
  always_comb begin
    adj_s = bcd_r;
    for (int n = 0; n < 3; n++) begin
      if (bcd_r[4*n +: 4] >= 4'd5) begin
        adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
      end else begin
        adj_s[4*n +: 4] = bcd_r[4*n +: 4];
      end
    end
  end

  // Iteration engine: load on start, shift 8 times, pulse done on the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= 8'd0;
      bcd_r   <= 12'd0;
      iter_r  <= 3'd0;
      run_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (start) begin
      shift_r <= bin;
      bcd_r   <= 12'd0;
      iter_r  <= 3'd0;
      run_r   <= 1'b1;
      done_r  <= 1'b0;
    end else if (run_r) begin
      {bcd_r, shift_r} <= {adj_s[10:0], shift_r, 1'b0};
      iter_r           <= iter_r + 3'd1;
      if (iter_r == 3'd7) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign bcd  = bcd_r;
endmodule

// File: rtl/result_display.sv
// Captures four 8-bit results, converts the current one to BCD and scans it
// onto a 3-digit multiplexed 7-segment display, rotating through the four.
module result_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 10000,
  parameter int DWELL    = 50000000
) (
  input logic              clk,
  input logic              rst,
  result_display_if.slave  bus
);
  localparam int DW_W = $clog2(DWELL);
  localparam int SC_W = $clog2(SCAN_DIV);

  state_t          state_r;
  logic [1:0]      idx_r;
  logic [7:0]      cap_r [4];
  logic [11:0]     shadow_r;
  logic            shadow_vld_r;
  logic [DW_W-1:0] dwell_r;
  logic [SC_W-1:0] scan_cnt_r;
  logic [1:0]      scan_sel_r;
  logic [2:0]      digit_r;
  logic [7:0]      seg_r;
  logic            busy_r;

  logic            wrap_s;
  logic [1:0]      idx_nxt_s;
  logic            start_s;
  logic [7:0]      bin_s;
  logic            bcd_done_s;
  logic [11:0]     bcd_s;
  logic [3:0]      nib_s;
  logic            blank_s;
  logic            dp_s;
  logic [7:0]      seg_s;
  logic [2:0]      digit_s;

  // Conversion start: a load (new data, index 0) wins over a dwell wrap.
  always_comb begin
    wrap_s    = (state_r == ST_SHOW) && (dwell_r == DW_W'(DWELL - 1));
    idx_nxt_s = idx_r + 2'd1;
    start_s   = bus.load | wrap_s;
    if (bus.load) begin
      bin_s = bus.r00;
    end else begin
      bin_s = cap_r[idx_nxt_s];
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .bin   (bin_s),
    .done  (bcd_done_s),
    .bcd   (bcd_s)
  );

  // Main FSM: capture, conversion tracking, atomic shadow update and dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 2'd0;
      cap_r[0]     <= 8'd0;
      cap_r[1]     <= 8'd0;
      cap_r[2]     <= 8'd0;
      cap_r[3]     <= 8'd0;
      shadow_r     <= 12'd0;
      shadow_vld_r <= 1'b0;
      dwell_r      <= '0;
      busy_r       <= 1'b0;
    end else if (bus.load) begin
      cap_r[0] <= bus.r00;
      cap_r[1] <= bus.r01;
      cap_r[2] <= bus.r10;
      cap_r[3] <= bus.r11;
      idx_r    <= 2'd0;
      dwell_r  <= '0;
      state_r  <= ST_CONVERT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_CONVERT: begin
          if (bcd_done_s) begin
            shadow_r     <= bcd_s;
            shadow_vld_r <= 1'b1;
            busy_r       <= 1'b0;
            dwell_r      <= '0;
            state_r      <= ST_SHOW;
          end else begin
            busy_r <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (wrap_s) begin
            idx_r   <= idx_nxt_s;
            dwell_r <= '0;
            state_r <= ST_CONVERT;
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Digit scan: parked on the ones position while idle, free-running otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_r <= '0;
      scan_sel_r <= 2'd0;
    end else if (state_r == ST_IDLE) begin
      scan_cnt_r <= '0;
      scan_sel_r <= 2'd0;
    end else if (scan_cnt_r == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= '0;
      if (scan_sel_r == 2'd2) begin
        scan_sel_r <= 2'd0;
      end else begin
        scan_sel_r <= scan_sel_r + 2'd1;
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + SC_W'(1);
    end
  end

  // Segment pattern for the scanned digit with leading-zero blanking and dp.
  always_comb begin
    case (scan_sel_r)
      2'd0: begin
        nib_s   = shadow_r[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        nib_s   = shadow_r[7:4];
        blank_s = (shadow_r[11:8] == 4'd0) && (shadow_r[7:4] == 4'd0);
      end
      2'd2: begin
        nib_s   = shadow_r[11:8];
        blank_s = (shadow_r[11:8] == 4'd0);
      end
      default: begin
        nib_s   = shadow_r[3:0];
        blank_s = 1'b0;
      end
    endcase
    dp_s = (idx_r == scan_sel_r);
    if ((state_r == ST_IDLE) || !shadow_vld_r) begin
      seg_s = SEG_BLANK;
    end else if (blank_s) begin
      seg_s = SEG_BLANK | {7'd0, dp_s};
    end else begin
      seg_s = seg_code(nib_s) | {7'd0, dp_s};
    end
    if (state_r == ST_IDLE) begin
      digit_s = DIG_OFF;
    end else begin
      digit_s = digit_onehot(scan_sel_r);
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_r <= DIG_OFF;
      seg_r   <= SEG_BLANK;
    end else begin
      digit_r <= digit_s;
      seg_r   <= seg_s;
    end
  end

  assign bus.digit    = digit_r;
  assign bus.seg_data = seg_r;
  assign bus.busy     = busy_r;
endmodule
